// File: rtl/serial_addsub_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// The master side issues start/sub/a/b and observes the status and result.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, ovf, zero
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice and a carry flop,
// LSB first, with result/cout/ovf/zero published once per operation.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  serial_addsub_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sBit;
  logic             carryNext;
  logic [WIDTH-1:0] sumNext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      opA_q    <= '0;
      opB_q    <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Subtraction is a + ~b + 1: the inverted b and carry-in of 1 are set at capture.
  always_comb begin
    sBit      = opA_q[0] ^ opB_q[0] ^ carry_q;
    carryNext = (opA_q[0] & opB_q[0]) | (opA_q[0] & carry_q) | (opB_q[0] & carry_q);
    sumNext   = {sBit, sum_q[WIDTH-1:1]};

    state_d  = state_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          opA_d   = bus.a;
          opB_d   = bus.b ^ {WIDTH{bus.sub}};
          carry_d = bus.sub;
          cnt_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        opA_d   = opA_q >> 1;
        opB_d   = opB_q >> 1;
        carry_d = carryNext;
        sum_d   = sumNext;
        cnt_d   = cnt_q + CNT_W'(1);
        busy_d  = 1'b1;
        // On the MSB slice carry_q is the carry into the MSB, so ovf is formed here.
        if (cnt_q == LAST) begin
          state_d  = DONE;
          cnt_d    = '0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = sumNext;
          cout_d   = carryNext;
          ovf_d    = carry_q ^ carryNext;
          zero_d   = (sumNext == '0);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised bit-serial adder/subtractor for the calculator datapath. A single full-adder slice plus a carry flip-flop processes one bit per clock, LSB first. Operands are captured on a start handshake, and the block reports the result with carry, signed-overflow and zero flags. It replaces a wide combinational ripple chain wherever area matters more than latency.

## Interface
Parameters:
- WIDTH, default 8: operand and result width in bits; legal range is WIDTH ≥ 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; sampled only in IDLE.
- sub  in  1  operation select: 0 = a + b, 1 = a − b. Captured with start.
- a  in  WIDTH  first operand; captured with start.
- b  in  WIDTH  second operand; captured with start.
- busy  out  1  high while an operation is in RUN.
- done  out  1  one-cycle pulse marking that result and flags are updated.
- result  out  WIDTH  sum or difference, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB. In subtract mode, 1 means no borrow (a ≥ b unsigned).
- ovf  out  1  two's-complement overflow = (carry into MSB) XOR (carry out of MSB).
- zero  out  1  result == 0.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - busy = 0.
  - If start = 1, latch: opA ← a; opB ← b XOR {WIDTH{sub}}; carry ← sub; bit counter ← 0. Go to RUN.
- **RUN, each cycle:**
  - s = opA[0] ^ opB[0] ^ carry.
  - carry ← majority(opA[0], opB[0], carry), i.e. (opA[0]&opB[0]) | (opA[0]&carry) | (opB[0]&carry).
  - opA and opB shift right by 1.
  - The internal sum shift register shifts right with s inserted at the MSB.
  - The carry into the MSB is recorded when counter = WIDTH−1.
  - counter increments. After the cycle with counter = WIDTH−1, go to DONE.
- **DONE (one cycle):**
  - done = 1.
  - result, cout, ovf and zero load from internal state in the edge entering DONE.
  - Next state is always IDLE.
- **Output holding:** result and flags hold their values until the next DONE. They never show partial sums during RUN.
- **start outside IDLE:** ignored in RUN and DONE. Operands on a, b and sub are not re-sampled. A start held high continuously re-triggers in the first IDLE cycle.
- **Flag widths:** internal carry is 1 bit. No output exceeds WIDTH bits. Wrap-around is modulo 2^WIDTH and is reported only through cout and ovf.
- **Reset:**
  - rst = 1 forces IDLE and counter = 0.
  - All outputs reset to 0: busy, done, result, cout, ovf, zero. Note zero resets to 0, not 1.
  - rst overrides start in the same cycle.
  - Reset during RUN or DONE aborts the operation. No done pulse follows.

## Timing
- **Start edge:** start is sampled at edge E0 in IDLE.
- **busy:** high in the cycles after E0 through E(WIDTH−1), i.e. exactly WIDTH cycles.
- **done and outputs:** done is high for exactly one cycle after edge E(WIDTH). result and flags become valid at that same edge.
- **Latency:** start to done = WIDTH + 1 cycles.
- **Initiation interval:** WIDTH + 2 cycles. The earliest next accepted start is in the IDLE cycle after done.
- **Registered outputs:** all outputs are driven from registers. There is no combinational path from inputs to outputs.

## Test plan
1. **Latency and basic add:** WIDTH=8, sub=0, a=8'h3C, b=8'h05, one-cycle start → busy high for 8 cycles; done pulses once, 9 cycles after the start edge; result=8'h41, cout=0, ovf=0, zero=0.
2. **Overflow and wrap-around:**
   - add 8'h7F + 8'h01 → result=8'h80, ovf=1, cout=0.
   - add 8'hFF + 8'h01 → result=8'h00, cout=1, zero=1, ovf=0.
3. **Subtract:**
   - 8'h05 − 8'h05 → 8'h00, zero=1, cout=1, ovf=0.
   - 8'h03 − 8'h05 → 8'hFE, cout=0.
   - 8'h80 − 8'h01 → 8'h7F, ovf=1.
4. **Exhaustive check:** WIDTH=4, all 512 (a, b, sub) combinations compared against a behavioural model for result, cout, ovf and zero. This proves the carry term uses all three operand pairs.
5. **Handshake:**
   - Re-pulse start with different operands during RUN → ignored; the original result is reported.
   - start high in the DONE cycle → ignored.
   - start in the IDLE cycle after done → accepted; second result correct.
6. **Reset:** assert rst in RUN cycle 3 → next cycle busy=0, done=0, result=0, all flags 0; no done pulse afterwards; the next operation completes normally.
